// File: rtl/food_tile_if.sv
// Bundle of the video, level-control and eat signals between the game/VGA side
// (master) and the food tile mapper (slave).
`default_nettype none

interface food_tile_if #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) ();
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int C_W   = $clog2(COLS * ROWS + 1);

  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             blank;
  logic             level_start;
  logic             eat_valid;
  logic [COL_W-1:0] eat_col;
  logic [ROW_W-1:0] eat_row;
  logic             eat_hit;
  logic             ready;
  logic [C_W-1:0]   food_remaining;
  logic             all_eaten;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;

  modport master (
    output DrawX, DrawY, blank, level_start, eat_valid, eat_col, eat_row,
    input  eat_hit, ready, food_remaining, all_eaten, red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, blank, level_start, eat_valid, eat_col, eat_row,
    output eat_hit, ready, food_remaining, all_eaten, red, green, blue
  );
endinterface

`default_nettype wire

// File: rtl/food_tile_mapper.sv
// Tile-grid food layer: scans the food ROM into a pellet map at level start,
// tracks eaten pellets and renders the tile colours with a 2-cycle pipeline.
`default_nettype none

module food_tile_mapper #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int COLS     = 16,
  parameter int ROWS     = 16,
  parameter int IDX_W    = 2,
  parameter int FOOD_IDX = 1,
  parameter int BG_IDX   = 0,
  parameter logic [COLS*ROWS*IDX_W-1:0] ROM_IMAGE = '0,
  parameter logic [(12<<IDX_W)-1:0]     PALETTE   = {12'h00F, 12'hF80, 12'hFF0, 12'h000}
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  food_tile_if.slave  bus
);
  localparam int N   = COLS * ROWS;
  localparam int A_W = $clog2(N);
  localparam int C_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RUN = 2'd2} state_t;

  state_t           state;
  logic [A_W-1:0]   scan_cnt;
  logic [A_W-1:0]   scan_a;
  logic             scan_v;
  logic [N-1:0]     pellet_map;
  logic [N-1:0]     eaten;
  logic [C_W-1:0]   food_remaining;
  logic             eat_hit;
  logic             ready;
  logic             all_eaten;

  logic [IDX_W-1:0] rom_q;
  logic [A_W-1:0]   addr1;
  logic             vis1;
  logic [11:0]      rgb;

  logic [A_W-1:0]   pix_addr;
  logic [A_W-1:0]   rom_addr;
  logic [A_W-1:0]   eat_addr;
  logic             in_view;
  logic             eat_in_range;
  logic             eat_ok;
  logic             is_food;
  logic [IDX_W-1:0] disp_idx;

  assign pix_addr = A_W'((32'(bus.DrawY) * 32'(ROWS) / 32'(V_RES)) * 32'(COLS)
                       + 32'(bus.DrawX) * 32'(COLS) / 32'(H_RES));
  assign in_view  = bus.blank && (32'(bus.DrawX) < 32'(H_RES)) && (32'(bus.DrawY) < 32'(V_RES));

  assign eat_in_range = (32'(bus.eat_col) < 32'(COLS)) && (32'(bus.eat_row) < 32'(ROWS));
  assign eat_addr     = A_W'(32'(bus.eat_row) * 32'(COLS) + 32'(bus.eat_col));
  // level_start takes priority over a simultaneous eat request
  assign eat_ok = (state == RUN) && bus.eat_valid && !bus.level_start && eat_in_range
                && pellet_map[eat_addr] && !eaten[eat_addr];

  // The scan owns the ROM port while it runs; otherwise the beam does
  assign rom_addr = (state == SCAN) ? scan_cnt : pix_addr;
  assign is_food  = (rom_q == IDX_W'(FOOD_IDX));
  assign disp_idx = (is_food && eaten[addr1]) ? IDX_W'(BG_IDX) : rom_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_q <= '0;
      addr1 <= '0;
      vis1  <= 1'b0;
      rgb   <= '0;
    end else begin
      rom_q <= ROM_IMAGE[32'(rom_addr) * IDX_W +: IDX_W];
      addr1 <= pix_addr;
      vis1  <= in_view && (state == RUN);
      rgb   <= (vis1 && (state == RUN) && !bus.level_start)
             ? PALETTE[32'(disp_idx) * 12 +: 12] : 12'h000;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      scan_cnt       <= '0;
      scan_a         <= '0;
      scan_v         <= 1'b0;
      pellet_map     <= '0;
      eaten          <= '0;
      food_remaining <= '0;
      eat_hit        <= 1'b0;
      ready          <= 1'b0;
      all_eaten      <= 1'b0;
    end else begin
      eat_hit <= 1'b0;
      if (bus.level_start) begin
        state          <= SCAN;
        scan_cnt       <= '0;
        scan_v         <= 1'b0;
        food_remaining <= '0;
        ready          <= 1'b0;
        all_eaten      <= 1'b0;
      end else begin
        case (state)
          SCAN: begin
            // rom_q lags the issued address by one cycle; scan_a/scan_v track it
            scan_v <= 1'b1;
            scan_a <= scan_cnt;
            if (scan_cnt != A_W'(N - 1))
              scan_cnt <= scan_cnt + A_W'(1);
            if (scan_v) begin
              pellet_map[scan_a] <= is_food;
              eaten[scan_a]      <= 1'b0;
              food_remaining     <= food_remaining + C_W'(is_food);
              if (scan_a == A_W'(N - 1)) begin
                state     <= RUN;
                ready     <= 1'b1;
                all_eaten <= ((food_remaining + C_W'(is_food)) == '0);
              end
            end
          end
          RUN: begin
            if (eat_ok) begin
              eaten[eat_addr] <= 1'b1;
              food_remaining  <= food_remaining - C_W'(1);
              eat_hit         <= 1'b1;
              if (food_remaining == C_W'(1))
                all_eaten <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.eat_hit        = eat_hit;
  assign bus.ready          = ready;
  assign bus.food_remaining = food_remaining;
  assign bus.all_eaten      = all_eaten;
  assign bus.red            = rgb[11:8];
  assign bus.green          = rgb[7:4];
  assign bus.blue           = rgb[3:0];
endmodule

`default_nettype wire

// File: tb/tb_food_tile_mapper.sv
// Bench for food_tile_mapper: pixel/eat expectations go through a due-cycle
// scoreboard; scan length, collisions and resets are hand-written sequences.
`default_nettype none

module tb_food_tile_mapper;
  function automatic logic is_pellet(input int t);
    case (t)
      3, 17, 20, 45, 88, 100, 130, 199, 240, 255: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] tile_idx(input int t);
    if (is_pellet(t)) return 2'd1;
    case (t % 3)
      0:       return 2'd0;
      1:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [511:0] make_rom();
    logic [511:0] r;
    r = '0;
    for (int t = 0; t < 256; t++) r[t*2 +: 2] = tile_idx(t);
    return r;
  endfunction

  localparam logic [511:0] ROM = make_rom();
  localparam logic [47:0]  PAL = {12'h123, 12'h456, 12'hABC, 12'h321};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  food_tile_if #(.COLS(16), .ROWS(16)) bus ();

  food_tile_mapper #(
    .H_RES(640), .V_RES(480), .COLS(16), .ROWS(16), .IDX_W(2),
    .FOOD_IDX(1), .BG_IDX(0), .ROM_IMAGE(ROM), .PALETTE(PAL)
  ) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [11:0] rgb_out;
  assign rgb_out = {bus.red, bus.green, bus.blue};

  typedef struct {
    int          due;
    int          kind;   // 0 rgb, 1 eat_hit, 2 food_remaining, 3 all_eaten
    logic [11:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        b;
    logic [11:0] exp;
    string       name;
  } pv_t;
  pv_t pv[10];

  int pel[10] = '{3, 17, 20, 45, 88, 100, 130, 199, 240, 255};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] exp, input int lat, input string nm);
    sb.push_back('{cyc + lat, kind, exp, nm});
  endtask

  sb_t         mon_e;
  logic [11:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        0:       mon_act = rgb_out;
        1:       mon_act = {11'b0, bus.eat_hit};
        2:       mon_act = 12'(bus.food_remaining);
        default: mon_act = {11'b0, bus.all_eaten};
      endcase
      chk(mon_e.name, 32'(mon_act), 32'(mon_e.exp));
    end
  end

  task automatic pix(input int x, input int y, input logic b, input logic [11:0] exp, input string nm);
    @(negedge clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
    push(0, exp, 2, nm);
  endtask

  task automatic eat_cycle(input int col, input int row, input logic hit, input int cnt, input string nm);
    @(negedge clk);
    bus.eat_valid = 1'b1;
    bus.eat_col   = 4'(col);
    bus.eat_row   = 4'(row);
    push(1, {11'b0, hit}, 1, {nm, "_hit"});
    if (cnt >= 0) push(2, 12'(cnt), 1, {nm, "_cnt"});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.eat_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      chk("drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.level_start = 1'b1;
    @(negedge clk);
    bus.level_start = 1'b0;
  endtask

  // Called on the first negedge after level_start was sampled
  task automatic wait_ready(input string nm);
    int   k;
    logic lit;
    k   = 0;
    lit = 1'b0;
    chk({nm, "_ready0"}, 32'(bus.ready), 32'd0);
    chk({nm, "_alleaten0"}, 32'(bus.all_eaten), 32'd0);
    while (!bus.ready && k < 400) begin
      if (rgb_out != 12'h000) lit = 1'b1;
      @(negedge clk);
      k++;
    end
    chk({nm, "_len"}, 32'(k), 32'd257);
    chk({nm, "_black"}, 32'(lit), 32'd0);
    chk({nm, "_count"}, 32'(bus.food_remaining), 32'd10);
    chk({nm, "_alleaten"}, 32'(bus.all_eaten), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({nm, "_ready"}, 32'(bus.ready), 32'd0);
    chk({nm, "_count"}, 32'(bus.food_remaining), 32'd0);
    chk({nm, "_alleaten"}, 32'(bus.all_eaten), 32'd0);
    chk({nm, "_hit"}, 32'(bus.eat_hit), 32'd0);
  endtask

  initial begin
    pv[0] = '{10'd40,  10'd30,  1'b1, 12'hABC, "tile17"};
    pv[1] = '{10'd40,  10'd30,  1'b0, 12'h000, "blanked"};
    pv[2] = '{10'd700, 10'd30,  1'b1, 12'h000, "x_out"};
    pv[3] = '{10'd40,  10'd480, 1'b1, 12'h000, "y_out"};
    pv[4] = '{10'd0,   10'd0,   1'b1, 12'h321, "tile0"};
    pv[5] = '{10'd639, 10'd479, 1'b1, 12'hABC, "tile255"};
    pv[6] = '{10'd40,  10'd29,  1'b1, 12'h456, "tile1"};
    pv[7] = '{10'd280, 10'd30,  1'b1, 12'h123, "tile23"};
    pv[8] = '{10'd160, 10'd30,  1'b1, 12'hABC, "tile20"};
    pv[9] = '{10'd639, 10'd30,  1'b1, 12'h456, "tile31"};

    reset_n         = 1'b0;
    bus.DrawX       = 10'd40;
    bus.DrawY       = 10'd30;
    bus.blank       = 1'b1;
    bus.level_start = 1'b0;
    bus.eat_valid   = 1'b0;
    bus.eat_col     = '0;
    bus.eat_row     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    eat_cycle(1, 1, 1'b0, 0, "idle_eat");
    idle();
    drain();

    pulse_start();
    wait_ready("scan1");

    foreach (pv[i]) pix(pv[i].x, pv[i].y, pv[i].b, pv[i].exp, pv[i].name);
    drain();

    eat_cycle(1, 1, 1'b1, 9, "eat17");
    idle();
    pix(40, 30, 1'b1, 12'h321, "eaten17_bg");
    eat_cycle(1, 1, 1'b0, 9, "re_eat17");
    eat_cycle(2, 1, 1'b0, 9, "eat_nonpellet");
    idle();
    drain();

    // level_start and eat in the same cycle: the eat must be dropped
    @(negedge clk);
    bus.level_start = 1'b1;
    bus.eat_valid   = 1'b1;
    bus.eat_col     = 4'd3;
    bus.eat_row     = 4'd0;
    push(1, 12'd0, 1, "collide_hit");
    @(negedge clk);
    bus.level_start = 1'b0;
    bus.eat_valid   = 1'b0;
    wait_ready("collide");
    pix(40, 30, 1'b1, 12'hABC, "restored17");
    drain();

    for (int i = 0; i < 10; i++) begin
      eat_cycle(pel[i] % 16, pel[i] / 16, 1'b1, 9 - i, $sformatf("b2b%0d", i));
      push(3, (i == 9) ? 12'd1 : 12'd0, 1, $sformatf("b2b%0d_all", i));
    end
    idle();
    drain();
    pulse_start();
    wait_ready("relevel");
    pix(40, 30, 1'b1, 12'hABC, "relevel17");
    pix(639, 479, 1'b1, 12'hABC, "relevel255");
    drain();

    // restart mid-scan (around address 100); an eat during SCAN is ignored
    pulse_start();
    repeat (48) @(negedge clk);
    eat_cycle(1, 1, 1'b0, -1, "scan_eat");
    idle();
    repeat (48) @(negedge clk);
    pulse_start();
    wait_ready("restart");
    drain();

    // asynchronous reset in the middle of a scan
    bus.DrawX = 10'd40;
    bus.DrawY = 10'd30;
    bus.blank = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("pre_reset_scan_count", 32'(bus.food_remaining), 32'd2);
    #2 reset_n = 1'b0;
    #1 check_zero("rst_scan");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_scan_idle_ready", 32'(bus.ready), 32'd0);
    chk("rst_scan_idle_rgb", 32'(rgb_out), 32'd0);

    pulse_start();
    wait_ready("after_rst");
    pix(40, 30, 1'b1, 12'hABC, "pre_rst_run17");
    drain();
    // asynchronous reset while running
    #2 reset_n = 1'b0;
    #1 check_zero("rst_run");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_run_idle_ready", 32'(bus.ready), 32'd0);
    chk("rst_run_idle_rgb", 32'(rgb_out), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
